// File: rtl/wb_stage.sv
// MEM/WB pipeline register with stall/flush, four-way result select, load alignment and x0 write suppression.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OFF_W      = $clog2(XLEN/8)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  reg_file_write_in,
    input  logic [REG_ADDR_W-1:0] addr_rd,
    input  logic [1:0]            select_mux_2,
    input  logic [2:0]            load_funct3,
    input  logic [OFF_W-1:0]      byte_off,
    input  logic [XLEN-1:0]       mem_out,
    input  logic [XLEN-1:0]       alu_out,
    input  logic [XLEN-1:0]       pc_plus4,
    input  logic [XLEN-1:0]       imm,
    output logic [XLEN-1:0]       mux_2_out,
    output logic [REG_ADDR_W-1:0] addr_out,
    output logic                  reg_file_write_out,
    output logic                  wb_valid
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [63:0]           retired_count
`endif
);

    logic                  valid_q;
    logic                  we_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [1:0]            sel_q;
    logic [2:0]            f3_q;
    logic [OFF_W-1:0]      off_q;
    logic [XLEN-1:0]       mem_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       pc4_q;
    logic [XLEN-1:0]       imm_q;

    // Flush only kills the valid bit; the payload is left as-is.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            sel_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            mem_q   <= '0;
            alu_q   <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!stall) begin
            valid_q <= in_valid;
            we_q    <= reg_file_write_in;
            rd_q    <= addr_rd;
            sel_q   <= select_mux_2;
            f3_q    <= load_funct3;
            off_q   <= byte_off;
            mem_q   <= mem_out;
            alu_q   <= alu_out;
            pc4_q   <= pc_plus4;
            imm_q   <= imm;
        end
    end

    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ld;

    assign sh = mem_q >> {off_q, 3'b000};

    always_comb begin
        ld = sh;
        case (f3_q)
            3'b000: ld = XLEN'($signed(sh[7:0]));
            3'b001: ld = XLEN'($signed(sh[15:0]));
            3'b100: ld = XLEN'(sh[7:0]);
            3'b101: ld = XLEN'(sh[15:0]);
            3'b010: if (XLEN == 64) ld = XLEN'($signed(sh[31:0]));
            3'b110: if (XLEN == 64) ld = XLEN'(sh[31:0]);
            default: ld = sh;
        endcase
    end

    always_comb begin
        mux_2_out = ld;
        case (sel_q)
            2'd1:    mux_2_out = alu_q;
            2'd2:    mux_2_out = pc4_q;
            2'd3:    mux_2_out = imm_q;
            default: mux_2_out = ld;
        endcase
    end

    assign reg_file_write_out = valid_q & we_q & (rd_q != '0);
    assign wb_valid           = valid_q;
    assign addr_out           = rd_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] cnt_q;

    // An instruction retires on the edge that moves it out of WB unstalled and unflushed.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else if (valid_q && !stall && !flush)
            cnt_q <= cnt_q + 64'd1;
    end

    assign retired_count = cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage (XLEN = 32) against a behavioural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush, we_in;
    logic [4:0]  addr_rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] mem_out, alu_out, pc_plus4, imm;
    logic [31:0] mux_2_out;
    logic [4:0]  addr_out;
    logic        reg_file_write_out, wb_valid;
`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] retired_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .reg_file_write_in(we_in), .addr_rd(addr_rd), .select_mux_2(sel),
        .load_funct3(f3), .byte_off(off), .mem_out(mem_out), .alu_out(alu_out),
        .pc_plus4(pc_plus4), .imm(imm), .mux_2_out(mux_2_out), .addr_out(addr_out),
        .reg_file_write_out(reg_file_write_out), .wb_valid(wb_valid)
`ifdef WB_RETIRE_COUNT_EN
        , .retired_count(retired_count)
`endif
    );

    // Model: the instruction sitting in WB, plus whether its payload is defined.
    logic        m_valid, m_we, m_known;
    logic [4:0]  m_rd;
    logic [1:0]  m_sel;
    logic [2:0]  m_f3;
    int          m_off;
    logic [31:0] m_mem, m_alu, m_pc4, m_imm;
    longint unsigned m_cnt;

    function automatic logic [31:0] align(logic [31:0] m, int o, logic [2:0] f);
        longint unsigned sh;
        longint v;
        sh = longint'(m) / (64'd1 << (8 * o));
        case (f)
            3'd0: begin v = longint'(sh % 256);   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = longint'(sh % 65536); if (v >= 32768) v = v - 65536; end
            3'd4: v = longint'(sh % 256);
            3'd5: v = longint'(sh % 65536);
            default: v = longint'(sh);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_data();
        case (m_sel)
            2'd0:    return align(m_mem, m_off, m_f3);
            2'd1:    return m_alu;
            2'd2:    return m_pc4;
            default: return m_imm;
        endcase
    endfunction

    function automatic logic exp_we();
        return m_valid && m_we && (m_rd != 5'd0);
    endfunction

    task automatic step();
        if (reset) begin
            m_valid = 0; m_we = 0; m_rd = 0; m_sel = 0; m_f3 = 0; m_off = 0;
            m_mem = 0; m_alu = 0; m_pc4 = 0; m_imm = 0; m_known = 1; m_cnt = 0;
        end else begin
            if (m_valid && !stall && !flush) m_cnt = m_cnt + 1;
            if (flush) begin
                m_valid = 0; m_known = 0;
            end else if (!stall) begin
                m_valid = in_valid; m_we = we_in; m_rd = addr_rd; m_sel = sel; m_f3 = f3;
                m_off = int'(off); m_mem = mem_out; m_alu = alu_out; m_pc4 = pc_plus4;
                m_imm = imm; m_known = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        reset = 0; stall = 0; flush = 0; in_valid = 0; we_in = 0; addr_rd = 0;
        sel = 0; f3 = 0; off = 0; mem_out = 0; alu_out = 0; pc_plus4 = 0; imm = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1; in_valid = 1; we_in = 1; addr_rd = 5'd9; sel = 2'd1; alu_out = 32'hDEADBEEF;
        step(); step();
        vectors += 4;
        if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        if (reg_file_write_out !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want 0", reg_file_write_out); end
        if (addr_out !== 5'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", addr_out); end
        if (mux_2_out !== 32'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", mux_2_out); end
        drive_idle();
    endtask

    task automatic test_alu_write();
        drive_idle();
        in_valid = 1; we_in = 1; addr_rd = 5'd5; sel = 2'd1; alu_out = 32'h12345678;
        step();
        drive_idle();
        vectors += 4;
        if (mux_2_out !== 32'h12345678) begin miscompares++; $display("FAIL alu_data got %h want 12345678", mux_2_out); end
        if (addr_out !== 5'd5) begin miscompares++; $display("FAIL alu_addr got %0d want 5", addr_out); end
        if (reg_file_write_out !== 1'b1) begin miscompares++; $display("FAIL alu_we got %b want 1", reg_file_write_out); end
        if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL alu_valid got %b want 1", wb_valid); end
    endtask

    task automatic test_x0();
        drive_idle();
        in_valid = 1; we_in = 1; addr_rd = 5'd0; sel = 2'd1; alu_out = 32'h5A5A5A5A;
        step();
        drive_idle();
        vectors += 2;
        if (reg_file_write_out !== 1'b0) begin miscompares++; $display("FAIL x0_we got %b want 0", reg_file_write_out); end
        if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL x0_valid got %b want 1", wb_valid); end
    endtask

    task automatic test_loads();
        logic [2:0]  tf [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
        logic [1:0]  to [5] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd3};
        logic [31:0] te [5] = '{32'hFFFFFF85, 32'h00000085, 32'hFFFF80F1, 32'h0000F17F, 32'h00000080};
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            in_valid = 1; we_in = 1; addr_rd = 5'd3; sel = 2'd0;
            mem_out = 32'h80F17F85; f3 = tf[i]; off = to[i];
            step();
            vectors++;
            if (mux_2_out !== te[i])
                begin miscompares++; $display("FAIL load_%0d f3=%b off=%0d got %h want %h", i, tf[i], to[i], mux_2_out, te[i]); end
        end
        drive_idle();
    endtask

    task automatic test_sources();
        drive_idle();
        in_valid = 1; we_in = 1; addr_rd = 5'd1; sel = 2'd2; pc_plus4 = 32'h00000104; imm = 32'h11111111;
        step();
        vectors++;
        if (mux_2_out !== 32'h00000104) begin miscompares++; $display("FAIL src_pc4 got %h want 00000104", mux_2_out); end
        sel = 2'd3; imm = 32'hFFFFF000;
        step();
        drive_idle();
        vectors++;
        if (mux_2_out !== 32'hFFFFF000) begin miscompares++; $display("FAIL src_imm got %h want FFFFF000", mux_2_out); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] v;
        v = $urandom;
        drive_idle();
        in_valid = 1; we_in = 1; addr_rd = 5'd7; sel = 2'd1; alu_out = v;
        step();
        for (int i = 0; i < 3; i++) begin
            stall = 1; in_valid = 1'($urandom); addr_rd = 5'($urandom); alu_out = $urandom; sel = 2'($urandom);
            step();
            vectors += 3;
            if (reg_file_write_out !== 1'b1) begin miscompares++; $display("FAIL stall%0d_we got %b want 1", i, reg_file_write_out); end
            if (addr_out !== 5'd7) begin miscompares++; $display("FAIL stall%0d_addr got %0d want 7", i, addr_out); end
            if (mux_2_out !== v) begin miscompares++; $display("FAIL stall%0d_data got %h want %h", i, mux_2_out, v); end
        end
        stall = 1; flush = 1; in_valid = 1;
        step();
        vectors += 2;
        if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", wb_valid); end
        if (reg_file_write_out !== 1'b0) begin miscompares++; $display("FAIL flush_we got %b want 0", reg_file_write_out); end
        drive_idle();
        step();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        in_valid = 1; we_in = 1; addr_rd = 5'd12; sel = 2'd1; alu_out = 32'hCAFEF00D;
        step();
        reset = 1; addr_rd = 5'd13;
        step();
        vectors += 3;
        if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", wb_valid); end
        if (addr_out !== 5'd0) begin miscompares++; $display("FAIL midrst_addr got %0d want 0", addr_out); end
        if (mux_2_out !== 32'd0) begin miscompares++; $display("FAIL midrst_data got %h want 0", mux_2_out); end
        drive_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 99) < 3);
            flush    = ($urandom_range(0, 99) < 10);
            stall    = ($urandom_range(0, 99) < 25);
            in_valid = ($urandom_range(0, 3) != 0);
            we_in    = 1'($urandom);
            addr_rd  = 5'($urandom);
            sel      = 2'($urandom);
            f3       = 3'($urandom);
            off      = 2'($urandom);
            mem_out  = $urandom; alu_out = $urandom; pc_plus4 = $urandom; imm = $urandom;
            step();
            vectors += 2;
            if (wb_valid !== m_valid) begin miscompares++; $display("FAIL rand%0d_valid got %b want %b", i, wb_valid, m_valid); end
            if (reg_file_write_out !== exp_we()) begin miscompares++; $display("FAIL rand%0d_we got %b want %b", i, reg_file_write_out, exp_we()); end
            if (m_known) begin
                vectors += 2;
                if (addr_out !== m_rd) begin miscompares++; $display("FAIL rand%0d_addr got %0d want %0d", i, addr_out, m_rd); end
                if (mux_2_out !== exp_data()) begin miscompares++; $display("FAIL rand%0d_data sel=%0d f3=%b got %h want %h", i, m_sel, m_f3, mux_2_out, exp_data()); end
            end
`ifdef WB_RETIRE_COUNT_EN
            vectors++;
            if (retired_count !== m_cnt) begin miscompares++; $display("FAIL rand%0d_count got %0d want %0d", i, retired_count, m_cnt); end
`endif
        end
        drive_idle();
    endtask

`ifdef WB_RETIRE_COUNT_EN
    task automatic test_retire();
        drive_idle();
        reset = 1;
        step();
        reset = 0;
        for (int i = 0; i < 12; i++) begin
            stall = (i == 3 || i == 8);
            in_valid = !stall; we_in = 1; addr_rd = 5'(i + 1); sel = 2'd1; alu_out = $urandom;
            step();
        end
        drive_idle();
        step();
        vectors++;
        if (retired_count !== 64'd10) begin miscompares++; $display("FAIL retire_count got %0d want 10", retired_count); end
        reset = 1;
        step();
        drive_idle();
        vectors++;
        if (retired_count !== 64'd0) begin miscompares++; $display("FAIL retire_reset got %0d want 0", retired_count); end
    endtask
`endif

    initial begin
        drive_idle();
        reset = 1;
        test_reset();
        test_alu_write();
        test_x0();
        test_loads();
        test_sources();
        test_stall_flush();
        test_reset_mid();
        test_random();
`ifdef WB_RETIRE_COUNT_EN
        test_retire();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
